// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register: drives the register-file and HI/LO write ports,
// applies the stage's flush/stall rules and counts retired writebacks.
module mem_wb_reg #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_wreg,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_whilo,
  input  logic [DATA_W-1:0]     mem_hi,
  input  logic [DATA_W-1:0]     mem_lo,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic                  wb_whilo,
  output logic [DATA_W-1:0]     wb_hi,
  output logic [DATA_W-1:0]     wb_lo,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      retire_cnt
);

  // $0 is hard-wired to zero, so a write there must never reach the register file.
  function automatic logic gpr_we(input logic valid, input logic wreg,
                                  input logic [REG_ADDR_W-1:0] wd);
    return valid & wreg & (wd != '0);
  endfunction

  logic bubble;
  logic hold;

  // MEM held but WB advancing: insert a bubble so WB does not re-execute.
  assign bubble = flush | (stall[4] & ~stall[5]);
  assign hold   = stall[4] & stall[5];

  logic                  we_p1;
  logic [REG_ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0]     wdata_p1;
  logic                  whilo_p1;
  logic [DATA_W-1:0]     hi_p1;
  logic [DATA_W-1:0]     lo_p1;
  logic                  vld_p1;
  logic [CNT_W-1:0]      cnt_p1;

  // MEM -> WB boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      whilo_p1 <= 1'b0;
      hi_p1    <= '0;
      lo_p1    <= '0;
      vld_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else if (bubble) begin
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      whilo_p1 <= 1'b0;
      hi_p1    <= '0;
      lo_p1    <= '0;
      vld_p1   <= 1'b0;
    end else if (!hold) begin
      we_p1    <= gpr_we(mem_valid, mem_wreg, mem_wd);
      waddr_p1 <= mem_wd;
      wdata_p1 <= mem_wdata;
      whilo_p1 <= mem_valid & mem_whilo;
      hi_p1    <= mem_hi;
      lo_p1    <= mem_lo;
      vld_p1   <= mem_valid;
      if (mem_valid) cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign wb_we      = we_p1;
  assign wb_waddr   = waddr_p1;
  assign wb_wdata   = wdata_p1;
  assign wb_whilo   = whilo_p1;
  assign wb_hi      = hi_p1;
  assign wb_lo      = lo_p1;
  assign wb_valid   = vld_p1;
  assign retire_cnt = cnt_p1;

  // WB stalled while MEM advances would lose an instruction.
  a_stall_order: assert property (@(posedge clk) disable iff (!rst)
    !(~stall[4] & stall[5]));
  a_no_r0_write: assert property (@(posedge clk) disable iff (!rst)
    !(wb_we && wb_waddr == '0));

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed table-driven bench for mem_wb_reg, plus async-reset and counter-wrap sequences.
module tb_mem_wb_reg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          mem_valid, mem_wreg, mem_whilo;
  logic [AW-1:0] mem_wd;
  logic [DW-1:0] mem_wdata, mem_hi, mem_lo;
  logic          wb_we, wb_whilo, wb_valid;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata, wb_hi, wb_lo;
  logic [CW-1:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  mem_wb_reg #(.REG_ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_valid(wb_valid), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    stall;
    logic          flush, valid, wreg;
    logic [AW-1:0] wd;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi, lo;
    logic          e_valid, e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_whilo;
    logic [DW-1:0] e_hi, e_lo;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".we"},    DW'(wb_we), '0);
    chk({tag, ".waddr"}, DW'(wb_waddr), '0);
    chk({tag, ".wdata"}, wb_wdata, '0);
    chk({tag, ".whilo"}, DW'(wb_whilo), '0);
    chk({tag, ".hi"},    wb_hi, '0);
    chk({tag, ".lo"},    wb_lo, '0);
    chk({tag, ".valid"}, DW'(wb_valid), '0);
    chk({tag, ".cnt"},   DW'(retire_cnt), '0);
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; mem_valid = v.valid; mem_wreg = v.wreg;
    mem_wd = v.wd; mem_wdata = v.wdata; mem_whilo = v.whilo; mem_hi = v.hi; mem_lo = v.lo;
  endtask

  initial begin
    //          stall      fl v  wr wd  wdata          whl hi     lo       | vld we waddr wdata       whl hi     lo     cnt
    tv[0]  = '{6'b000000, 0, 1, 1, 5,  32'hDEADBEEF, 0, 32'h0, 32'h0,     1, 1, 5, 32'hDEADBEEF, 0, 32'h0, 32'h0, 1};
    tv[1]  = '{6'b000000, 0, 1, 1, 0,  32'h11,       0, 32'h0, 32'h0,     1, 0, 0, 32'h11,       0, 32'h0, 32'h0, 2};
    tv[2]  = '{6'b010000, 0, 1, 1, 3,  32'h33,       0, 32'h0, 32'h0,     0, 0, 0, 32'h0,        0, 32'h0, 32'h0, 2};
    tv[3]  = '{6'b000000, 0, 1, 1, 3,  32'h33,       0, 32'h0, 32'h0,     1, 1, 3, 32'h33,       0, 32'h0, 32'h0, 3};
    tv[4]  = '{6'b000000, 0, 0, 1, 4,  32'h44,       1, 32'h1, 32'h2,     0, 0, 4, 32'h44,       0, 32'h1, 32'h2, 3};
    tv[5]  = '{6'b000000, 0, 1, 0, 9,  32'h55,       1, 32'hA, 32'hB,     1, 0, 9, 32'h55,       1, 32'hA, 32'hB, 4};
    tv[6]  = '{6'b000000, 0, 1, 1, 7,  32'h1234,     0, 32'h0, 32'h0,     1, 1, 7, 32'h1234,     0, 32'h0, 32'h0, 5};
    tv[7]  = '{6'b110000, 0, 1, 1, 8,  32'h9999,     1, 32'hFF, 32'hEE,   1, 1, 7, 32'h1234,     0, 32'h0, 32'h0, 5};
    tv[8]  = '{6'b110000, 0, 1, 1, 9,  32'h8888,     1, 32'hFE, 32'hED,   1, 1, 7, 32'h1234,     0, 32'h0, 32'h0, 5};
    tv[9]  = '{6'b110000, 0, 1, 1, 10, 32'h7777,     0, 32'hFD, 32'hEC,   1, 1, 7, 32'h1234,     0, 32'h0, 32'h0, 5};
    tv[10] = '{6'b110000, 1, 1, 1, 11, 32'h6666,     1, 32'h5, 32'h6,     0, 0, 0, 32'h0,        0, 32'h0, 32'h0, 5};
    tv[11] = '{6'b000000, 1, 1, 1, 12, 32'h5555,     1, 32'h5, 32'h6,     0, 0, 0, 32'h0,        0, 32'h0, 32'h0, 5};
    tv[12] = '{6'b000001, 0, 1, 1, 2,  32'h22,       0, 32'h3, 32'h4,     1, 1, 2, 32'h22,       0, 32'h3, 32'h4, 6};

    // reset held with random inputs across clock edges
    rst = 1'b0; stall = '0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'($urandom); mem_wreg = 1'($urandom); mem_wd = AW'($urandom);
      mem_wdata = $urandom; mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
      flush = 1'($urandom);
      @(posedge clk); #1;
    end
    chk_all_zero("reset");
    flush = 1'b0; stall = '0;
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tv[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), DW'(wb_valid), DW'(tv[i].e_valid));
      chk($sformatf("v%0d.we", i),    DW'(wb_we),    DW'(tv[i].e_we));
      chk($sformatf("v%0d.waddr", i), DW'(wb_waddr), DW'(tv[i].e_waddr));
      chk($sformatf("v%0d.wdata", i), wb_wdata,      tv[i].e_wdata);
      chk($sformatf("v%0d.whilo", i), DW'(wb_whilo), DW'(tv[i].e_whilo));
      chk($sformatf("v%0d.hi", i),    wb_hi,         tv[i].e_hi);
      chk($sformatf("v%0d.lo", i),    wb_lo,         tv[i].e_lo);
      chk($sformatf("v%0d.cnt", i),   DW'(retire_cnt), DW'(tv[i].e_cnt));
    end

    // asynchronous reset between edges clears outputs without a clock edge
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    stall = '0; flush = 1'b0;
    rst = 1'b1;

    // counter wrap: 17 valid instructions on a 4-bit counter leaves 1
    mem_valid = 1'b1; mem_wreg = 1'b1; mem_whilo = 1'b0;
    for (int i = 0; i < 17; i++) begin
      mem_wd = AW'(i + 1); mem_wdata = DW'(i);
      @(posedge clk); #1;
    end
    chk("wrap.cnt",   DW'(retire_cnt), 32'd1);
    chk("wrap.waddr", DW'(wb_waddr),   32'd17);
    chk("wrap.wdata", wb_wdata,        32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- MEM→WB pipeline register of the 5-stage MIPS32 core.
- Captures the MEM-stage write intent and drives the register file write port (we/waddr/wdata), so it is the writer the register file responds to.
- Also carries HI/LO write intent and keeps a retired-writeback counter for debug.
- Implements the core's stall/flush rules for this stage boundary.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- DATA_W, 32, register and HI/LO data width.
- CNT_W, 32, retired-writeback counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  6  pipeline stall vector; bit 4 = MEM stage, bit 5 = WB stage.
- flush  in  1  exception/eret flush; 1 = squash.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wreg  in  1  MEM instruction writes a GPR.
- mem_wd  in  REG_ADDR_W  destination GPR.
- mem_wdata  in  DATA_W  GPR write data.
- mem_whilo  in  1  MEM instruction writes HI/LO.
- mem_hi  in  DATA_W  HI write data.
- mem_lo  in  DATA_W  LO write data.
- wb_we  out  1  register-file write enable.
- wb_waddr  out  REG_ADDR_W  register-file write address.
- wb_wdata  out  DATA_W  register-file write data.
- wb_whilo  out  1  HI/LO write enable.
- wb_hi  out  DATA_W  HI data.
- wb_lo  out  DATA_W  LO data.
- wb_valid  out  1  WB stage holds a real instruction.
- retire_cnt  out  CNT_W  count of valid instructions accepted into WB.

Behaviour:
- Reset (rst=0, asynchronous; takes effect immediately, independent of clk):
  - every output is 0, including retire_cnt.
  - Reset mid-stall or mid-flush wins over everything.
- Per rising edge, priority order:
  1. flush=1 → load bubble: wb_valid, wb_we and wb_whilo = 0; address/data fields = 0. retire_cnt unchanged. Flush beats stall.
  2. stall[4]=1 and stall[5]=0 → load bubble, same as flush. MEM is held and WB must not re-execute.
  3. stall[4]=1 and stall[5]=1 → hold all registers, counter included.
  4. stall[4]=0 → capture MEM fields:
     - wb_valid = mem_valid.
     - wb_we = mem_valid & mem_wreg & (mem_wd != 0). Writes to $0 are suppressed here; the register file must never see we=1 with waddr=0.
     - wb_waddr = mem_wd.
     - wb_wdata = mem_wdata.
     - wb_whilo = mem_valid & mem_whilo.
     - wb_hi = mem_hi, wb_lo = mem_lo.
     - retire_cnt += 1 iff mem_valid=1.
- stall[4]=0 with stall[5]=1 is illegal. Treat it as case 4 (capture), and the assertion bench flags it.
- Latency: exactly one cycle MEM→WB.
  - The register file sees the write combinationally from wb_* and commits it at the next edge.
  - Its same-cycle read bypass handles the RAW hazard; no bypass logic is needed here.
- When wb_valid=0, the outputs wb_we and wb_whilo are 0.
- retire_cnt wraps modulo 2^CNT_W with no saturation and no flag.
- No combinational path from any input to any output; all outputs come straight from registers.

Test Plan:
- Reset: hold rst=0 with random inputs, then toggle clk → all outputs 0. Release rst; mem_valid=1, mem_wreg=1, mem_wd=5, mem_wdata=0xDEADBEEF, stall=0 → after one edge: wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF, retire_cnt=1.
- $0 suppression: mem_wd=0, mem_wreg=1, mem_valid=1 → wb_we=0, wb_valid=1, retire_cnt increments.
- Bubble: stall=6'b010000 with a valid write on MEM inputs → wb_we=0, wb_valid=0, retire_cnt unchanged. Next cycle stall=0 → the write appears.
- Hold: load write to r7=0x1234, then stall=6'b110000 for 3 cycles while MEM inputs change → wb_waddr=7, wb_wdata=0x1234 held, retire_cnt constant.
- Flush priority: flush=1 together with stall=6'b110000 → bubble, not hold. Also assert rst=0 between edges → outputs clear immediately, asynchronously.
- HI/LO and wrap: mem_whilo=1, mem_hi=0xA, mem_lo=0xB → wb_whilo=1, wb_hi=0xA, wb_lo=0xB. With CNT_W=4, run 17 valid instructions → retire_cnt=1.
